uart_alu_ctrl: RTL and testbench

Sequencer between the UART receiver/transmitter pair and a combinational ALU. It collects three framed bytes from the RX side (operand A, operand B, opcode) and drives them onto registered ALU inputs. It then captures the ALU result and launches a single-byte TX transmission of it, returning to wait for the next frame. Sits in the top-level next to the baud generator, RX and TX, replacing the direct RX-to-TX echo path.

---
 rtl/uart_alu_ctrl.sv | 150 +++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - frame sequencer between UART RX/TX and a combinational ALU
// Collects A, B, opcode bytes, runs the ALU for one cycle and sends the result byte.
module uart_alu_ctrl #(
    parameter int NBIT_DATA      = 8,
    parameter int NBIT_OP        = 6,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 rx_done_tick,
    input  logic [NBIT_DATA-1:0] rx_data,
    input  logic                 tx_done_tick,
    input  logic [NBIT_DATA-1:0] alu_result,
    output logic [NBIT_DATA-1:0] alu_a,
    output logic [NBIT_DATA-1:0] alu_b,
    output logic [NBIT_OP-1:0]   alu_op,
    output logic                 tx_start,
    output logic [NBIT_DATA-1:0] tx_data,
    output logic                 busy,
    output logic                 timeout_tick,
    output logic                 overrun
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t                 state_q, state_d;
    logic [NBIT_DATA-1:0]   alu_a_q, alu_a_d;
    logic [NBIT_DATA-1:0]   alu_b_q, alu_b_d;
    logic [NBIT_OP-1:0]     alu_op_q, alu_op_d;
    logic [NBIT_DATA-1:0]   tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic                   timeout_q, timeout_d;
    logic                   overrun_q, overrun_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_state;
    logic                   expire;

    assign busy_state = (state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX);
    // An arriving byte always beats an expiring counter.
    assign expire = TO_EN && !rx_done_tick && (cnt_q == CNT_LAST)
                    && ((state_q == WAIT_B) || (state_q == WAIT_OP));

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        overrun_d  = overrun_q;
        cnt_d      = '0;

        if (rx_done_tick && busy_state) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            WAIT_A: begin
                if (rx_done_tick) begin
                    alu_a_d = rx_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (rx_done_tick) begin
                    alu_b_d = rx_data;
                    state_d = WAIT_OP;
                end else if (expire) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_OP: begin
                if (rx_done_tick) begin
                    alu_op_d = rx_data[NBIT_OP-1:0];
                    state_d  = EXEC;
                end else if (expire) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                state_d = SEND;
            end
            SEND: begin
                tx_data_d  = alu_result;
                tx_start_d = 1'b1;
                state_d    = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done_tick) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign timeout_tick = timeout_q;
    assign overrun      = overrun_q;
    assign busy         = busy_state;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb/tb_uart_alu_ctrl.sv - self-checking bench for uart_alu_ctrl
module tb_uart_alu_ctrl;

    localparam int TO = 100;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       tx_done_tick;
    logic [7:0] alu_result;
    logic [7:0] alu_a, alu_b, tx_data;
    logic [5:0] alu_op;
    logic       tx_start, busy, timeout_tick, overrun;

    int errors = 0;
    int checks = 0;
    int tx_pulses = 0;
    int to_pulses = 0;
    int frames_sent = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [7:0] res;
    } vec_t;
    vec_t vecs[7];

    uart_alu_ctrl #(.NBIT_DATA(8), .NBIT_OP(6), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .reset(rst_n),
        .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .tx_done_tick(tx_done_tick), .alu_result(alu_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .tx_start(tx_start), .tx_data(tx_data), .busy(busy),
        .timeout_tick(timeout_tick), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    // Bench ALU: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR.
    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            6'h24:   alu_result = alu_a & alu_b;
            6'h25:   alu_result = alu_a | alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (rst_n) begin
            if (timeout_tick) to_pulses++;
            if (tx_start) begin
                tx_pulses++;
                if (exp_q.size() == 0) begin
                    check("unexpected_tx_start", 1, 0);
                end else begin
                    check("tx_data", tx_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d);
        @(posedge CLK);
        #1 rx_data = d; rx_done_tick = 1'b1;
        @(posedge CLK);
        #1 rx_done_tick = 1'b0;
    endtask

    // Call right after the opcode byte; checks latency, busy and the TX handshake.
    task automatic finish_frame(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] opb, input bit inject);
        frames_sent++;
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            check("tx_start_latency", tx_start, (k == 3));
            check("busy_exec", busy, 1);
            if (k == 1) begin
                check("alu_a", alu_a, a);
                check("alu_b", alu_b, b);
                check("alu_op", alu_op, opb & 8'h3F);
            end
        end
        if (inject) begin
            send_byte(8'hAA);
            @(negedge CLK);
            check("overrun_set", overrun, 1);
            check("alu_a_after_drop", alu_a, a);
            check("busy_wait_tx", busy, 1);
        end
        repeat (2) @(posedge CLK);
        #1 tx_done_tick = 1'b1;
        @(posedge CLK);
        #1 tx_done_tick = 1'b0;
        @(negedge CLK);
        check("busy_after_done", busy, 0);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] opb, input logic [7:0] res, input bit inject);
        exp_q.push_back(res);
        send_byte(a);
        send_byte(b);
        send_byte(opb);
        finish_frame(a, b, opb, inject);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hits;
        int at;
        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
        vecs[1] = '{8'hFF, 8'h01, 8'h20, 8'h00};
        vecs[2] = '{8'h0F, 8'hF0, 8'h24, 8'h00};
        vecs[3] = '{8'hC8, 8'h37, 8'h22, 8'h91};
        vecs[4] = '{8'hA5, 8'h5A, 8'h25, 8'hFF};
        vecs[5] = '{8'h3C, 8'h0F, 8'h24, 8'h0C};
        vecs[6] = '{8'h12, 8'h34, 8'hE0, 8'h46};

        rst_n = 1'b0; rx_done_tick = 1'b0; rx_data = 8'h00; tx_done_tick = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_flags", {tx_start, busy, timeout_tick, overrun}, 0);
        @(posedge CLK);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) send_frame(vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].res, 1'b0);
        check("overrun_clean", overrun, 0);

        send_frame(8'h10, 8'h20, 8'h22, 8'hF0, 1'b1);

        // Partial frame abandoned: tick in the cycle after the counter hits TO-1.
        send_byte(8'h11);
        hits = 0; at = 0;
        for (int k = 1; k <= TO + 5; k++) begin
            @(negedge CLK);
            if (timeout_tick) begin
                hits++;
                at = k;
            end
        end
        check("timeout_count", hits, 1);
        check("timeout_cycle", at, TO + 1);
        check("alu_a_stale", alu_a, 8'h11);
        check("busy_after_timeout", busy, 0);
        send_frame(8'h02, 8'h03, 8'h20, 8'h05, 1'b0);
        check("overrun_sticky", overrun, 1);

        // Byte lands in the very cycle the counter would expire.
        send_byte(8'h33);
        repeat (TO - 2) @(posedge CLK);
        send_byte(8'h44);
        hits = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (timeout_tick) hits++;
        end
        check("no_timeout_on_byte", hits, 0);
        check("alu_b_boundary", alu_b, 8'h44);
        exp_q.push_back(8'h77);
        send_byte(8'h20);
        finish_frame(8'h33, 8'h44, 8'h20, 1'b0);
        check("total_timeouts", to_pulses, 1);

        // Asynchronous reset mid-frame.
        send_byte(8'h07);
        send_byte(8'h09);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_alu_a", alu_a, 0);
        check("async_rst_alu_b", alu_b, 0);
        check("async_rst_tx_data", tx_data, 0);
        check("async_rst_overrun", overrun, 0);
        repeat (3) @(posedge CLK);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge CLK);
        check("no_tx_after_reset", {tx_start, busy}, 0);
        send_frame(8'h01, 8'h01, 8'h20, 8'h02, 1'b0);

        check("tx_pulse_total", tx_pulses, frames_sent);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
